// File: rtl/ysyx_22040895_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the fetch PC, issues one
//            instruction-memory request at a time, waits for the response,
//            and holds the fetched instruction until decode accepts it.
//            Execute-stage redirects take priority; wrong-path responses
//            are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040895_fetch_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [INST_W-1:0]   inst;
  logic [ADDR_W-1:0]   inst_pc;
  logic                drop;
  logic                misalign;

  // A redirect only takes effect when its target is word aligned; a
  // misaligned target is reported and otherwise has no effect.
  logic redir_ok;
  logic redir_bad;
  logic out_state;
  logic inst_fire;

  assign redir_ok  = redirect_valid_i & (redirect_pc_i[1:0] == 2'b00);
  assign redir_bad = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
  assign out_state = (state == S_OUT);
  // Any redirect (even a misaligned one) hides the held instruction for the
  // cycle, so decode never consumes it while execute is steering away.
  assign inst_fire = out_state & ~redirect_valid_i & inst_ready_i;

  // Fetch sequencer: state, PC, held instruction, drop flag, misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= redir_bad;
      case (state)
        S_REQ: begin
          if (redir_ok) begin
            pc <= redirect_pc_i;
            // Memory already took the old address this cycle, so its
            // response belongs to the wrong path and must be discarded.
            if (imem_req_ready_i) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_req_ready_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redir_ok) begin
            pc <= redirect_pc_i;
            if (imem_rsp_valid_i) begin
              // Response consumed here, nothing left in flight to drop.
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rsp_valid_i) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst    <= imem_rsp_data_i;
              inst_pc <= pc;
              state   <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (redir_ok) begin
            pc    <= redirect_pc_i;
            state <= S_REQ;
          end else if (inst_fire) begin
            pc    <= pc + PC_STEP;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  // Every output is forced to zero while reset is held.
  assign imem_req_valid_o = ~rst & (state == S_REQ);
  assign imem_req_addr_o  = rst ? '0 : pc;
  assign inst_valid_o     = ~rst & out_state & ~redirect_valid_i;
  assign inst_o           = rst ? '0 : inst;
  assign inst_pc_o        = rst ? '0 : inst_pc;
  assign misalign_o       = ~rst & misalign;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040895_fetch_ctrl
// Purpose  : Cycle-table bench for the fetch sequencer. Each record holds one
//            cycle of inputs and the outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040895_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        e_reqv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_mis;
  } vec_t;

  localparam logic [63:0] R   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] T   = 64'h0000_0000_8000_1000;
  localparam logic [63:0] T2  = 64'h0000_0000_8000_2000;
  localparam logic [63:0] T3  = 64'h0000_0000_8000_3000;
  localparam logic [63:0] T4  = 64'h0000_0000_8000_4000;
  localparam logic [63:0] MIS = 64'h0000_0000_8000_0002;
  localparam logic [63:0] W   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] I0  = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] I3  = 32'h0030_0193;
  localparam logic [31:0] I4  = 32'h0040_0213;
  localparam logic [31:0] I5  = 32'h0050_0293;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_ready = 1'b0;

  logic        a_reqv, a_iv, a_mis;
  logic [63:0] a_addr, a_ipc;
  logic [31:0] a_inst;
  logic        b_reqv, b_iv, b_mis;
  logic [63:0] b_addr, b_ipc;
  logic [31:0] b_inst;

  int tests = 0;
  int fails = 0;

  vec_t tab_main[$];
  vec_t tab_wrap[$];

  always #5 clk = ~clk;

  ysyx_22040895_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(a_reqv), .imem_req_addr_o(a_addr),
    .imem_req_ready_i(req_ready), .imem_rsp_valid_i(rsp_valid),
    .imem_rsp_data_i(rsp_data), .inst_valid_o(a_iv), .inst_o(a_inst),
    .inst_pc_o(a_ipc), .inst_ready_i(inst_ready), .misalign_o(a_mis)
  );

  ysyx_22040895_fetch_ctrl #(.RESET_PC(W)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(b_reqv), .imem_req_addr_o(b_addr),
    .imem_req_ready_i(req_ready), .imem_rsp_valid_i(rsp_valid),
    .imem_rsp_data_i(rsp_data), .inst_valid_o(b_iv), .inst_o(b_inst),
    .inst_pc_o(b_ipc), .inst_ready_i(inst_ready), .misalign_o(b_mis)
  );

  function automatic vec_t mk(
    input logic r, input logic rv, input logic [63:0] rpc, input logic rdy,
    input logic rspv, input logic [31:0] rspd, input logic irdy,
    input logic ereqv, input logic [63:0] eaddr, input logic eiv,
    input logic [31:0] einst, input logic [63:0] eipc, input logic emis);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv;
    v.rspd = rspd; v.irdy = irdy; v.e_reqv = ereqv; v.e_addr = eaddr;
    v.e_iv = eiv; v.e_inst = einst; v.e_ipc = eipc; v.e_mis = emis;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, then check outputs.
  task automatic apply(input vec_t v, input bit use_wrap, input string nm, input int idx);
    logic [162:0] act;
    logic [162:0] exp;
    @(negedge clk);
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    req_ready      = v.rdy;
    rsp_valid      = v.rspv;
    rsp_data       = v.rspd;
    inst_ready     = v.irdy;
    #1;
    if (use_wrap) act = {b_reqv, b_addr, b_iv, b_inst, b_ipc, b_mis};
    else          act = {a_reqv, a_addr, a_iv, a_inst, a_ipc, a_mis};
    exp = {v.e_reqv, v.e_addr, v.e_iv, v.e_inst, v.e_ipc, v.e_mis};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] {reqv,addr,iv,inst,ipc,mis} got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  initial begin
    // Reset, sequential fetch, backpressure.
    tab_main.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,0,0));
    tab_main.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,0,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,R,0,0,0,0));
    tab_main.push_back(mk(0,0,0,1,1,I0,1,     0,R,0,0,0,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      0,R,1,I0,R,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,R+4,0,I0,R,0));
    tab_main.push_back(mk(0,0,0,1,1,I1,1,     0,R+4,0,I0,R,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      0,R+4,1,I1,R+4,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,R+8,0,I1,R+4,0));
    tab_main.push_back(mk(0,0,0,1,1,I2,0,     0,R+8,0,I1,R+4,0));
    for (int k = 0; k < 5; k++)
      tab_main.push_back(mk(0,0,0,1,0,0,0,    0,R+8,1,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      0,R+8,1,I2,R+8,0));
    // Request held without ready, then accepted.
    tab_main.push_back(mk(0,0,0,0,0,0,1,      1,R+12,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,R+12,0,I2,R+8,0));
    // Redirect in WAIT, wrong-path response two cycles later is dropped.
    tab_main.push_back(mk(0,1,T,1,0,0,1,      0,R+12,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      0,T,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,1,32'hDEADBEEF,1, 0,T,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,T,0,I2,R+8,0));
    // Redirect coincident with response.
    tab_main.push_back(mk(0,1,T2,1,1,32'h11111111,1, 0,T,0,I2,R+8,0));
    // Redirect coincident with request acceptance.
    tab_main.push_back(mk(0,1,T3,1,0,0,1,     1,T2,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,1,32'h22222222,1, 0,T3,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,T3,0,I2,R+8,0));
    tab_main.push_back(mk(0,0,0,1,1,I3,1,     0,T3,0,I2,R+8,0));
    // Misaligned redirect in OUT.
    tab_main.push_back(mk(0,1,MIS,1,0,0,1,    0,T3,0,I3,T3,0));
    tab_main.push_back(mk(0,0,0,1,0,0,0,      0,T3,1,I3,T3,1));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      0,T3,1,I3,T3,0));
    // Response outside WAIT is ignored.
    tab_main.push_back(mk(0,0,0,0,1,32'h99,1, 1,T3+4,0,I3,T3,0));
    tab_main.push_back(mk(0,0,0,1,0,0,1,      1,T3+4,0,I3,T3,0));
    tab_main.push_back(mk(0,0,0,1,1,I4,1,     0,T3+4,0,I3,T3,0));
    // Aligned redirect in OUT discards the held instruction.
    tab_main.push_back(mk(0,1,T4,1,0,0,1,     0,T3+4,0,I4,T3+4,0));
    tab_main.push_back(mk(0,0,0,0,0,0,1,      1,T4,0,I4,T3+4,0));

    // Wrap from the top of the address space, then reset during WAIT.
    tab_wrap.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,0,0));
    tab_wrap.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,1,0,0,1,      1,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,1,1,I0,1,     0,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,1,0,0,1,      0,W,1,I0,W,0));
    tab_wrap.push_back(mk(0,0,0,1,0,0,1,      1,0,0,I0,W,0));
    tab_wrap.push_back(mk(1,0,0,1,0,0,1,      0,0,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,0,1,32'hBAD,1, 1,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,0,0,0,1,      1,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,1,0,0,1,      1,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,1,1,I5,1,     0,W,0,0,0,0));
    tab_wrap.push_back(mk(0,0,0,0,0,0,1,      0,W,1,I5,W,0));

    foreach (tab_main[i]) apply(tab_main[i], 1'b0, "main", i);
    foreach (tab_wrap[i]) apply(tab_wrap[i], 1'b1, "wrap", i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040895_fetch_ctrl.md
# ysyx_22040895_fetch_ctrl

Instruction-fetch sequencer for the ysyx_22040895 core. It owns the fetch PC and replaces the free-running per-cycle PC update with a multi-cycle handshake. It issues one request at a time to instruction memory, waits for the response, and holds the fetched instruction until decode accepts it. Redirects from execute (branch or jump target) take priority. Wrong-path responses are discarded.

## Interface
- RESET_PC, 64'h0000000080000000, first fetch address after reset
- ADDR_W, 64, PC / address width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- redirect_valid_i  in  1  execute requests PC redirect this cycle
- redirect_pc_i  in  ADDR_W  redirect target
- imem_req_valid_o  out  1  fetch request valid
- imem_req_addr_o  out  ADDR_W  fetch address (current pc)
- imem_req_ready_i  in  1  memory accepts request
- imem_rsp_valid_i  in  1  response data valid
- imem_rsp_data_i  in  INST_W  fetched instruction
- inst_valid_o  out  1  instruction to decode valid
- inst_o  out  INST_W  held instruction
- inst_pc_o  out  ADDR_W  PC of held instruction
- inst_ready_i  in  1  decode accepts instruction
- misalign_o  out  1  one-cycle pulse: redirect target not 4-byte aligned

## Operation
- State: 2-bit FSM {REQ, WAIT, OUT}.
- Registers: pc, inst, inst_pc, drop flag.
- Reset: state=REQ; pc=RESET_PC; drop=0; inst=0; inst_pc=0; misalign_o=0.
- All outputs read 0 while rst is high.
- REQ:
  - imem_req_valid_o=1; imem_req_addr_o=pc.
  - On imem_req_ready_i, go to WAIT.
- WAIT:
  - On imem_rsp_valid_i with drop=1: clear drop and return to REQ. No output.
  - On imem_rsp_valid_i with drop=0: inst<=rsp_data, inst_pc<=pc, go to OUT.
- OUT:
  - inst_valid_o = (state==OUT) & ~redirect_valid_i. This is the only combinational input-to-output path.
  - On inst_valid_o & inst_ready_i: pc<=pc+4, go to REQ.
- Redirect with aligned target (redirect_pc_i[1:0]==0) has priority over everything except rst. pc<=redirect_pc_i in every state, plus:
  - REQ without ready: stay in REQ with the new pc.
  - REQ with ready in the same cycle: the old-address request is committed; drop<=1, go to WAIT.
  - WAIT without rsp: drop<=1, stay in WAIT.
  - WAIT with rsp in the same cycle: discard the response, go to REQ.
  - OUT: discard the held instruction, go to REQ. inst_ready_i is ignored.
- Misaligned redirect (redirect_pc_i[1:0]!=0):
  - misalign_o=1 on the next cycle, for one cycle.
  - Redirect otherwise ignored: no pc or state change.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Responses arriving outside WAIT are ignored.
- At most one request is outstanding.
- Reset mid-operation: abandons any outstanding request. The memory side must be reset together with this block.

## Timing
- Zero-wait memory (ready=1, response one cycle after acceptance):
  - cycle n: REQ, request accepted
  - n+1: WAIT, rsp
  - n+2: OUT, inst_valid_o=1
  - n+3: next REQ if decode was ready at n+2
- Throughput: one instruction per 3 cycles.
- Redirect asserted in cycle n: next non-dropped request carries the target at the earliest in n+1 (from OUT or REQ). From WAIT it comes after the pending response returns.
- inst_o and inst_pc_o stay stable while inst_valid_o=1 and inst_ready_i=0.
- imem_req_addr_o is stable while imem_req_valid_o=1 and not accepted, unless a redirect occurs.

## Test plan
- Reset: rst high 2 cycles → all outputs 0. The cycle after release, imem_req_valid_o=1 with addr 0x80000000.
- Sequential fetch, zero-wait memory, decode always ready, rsp data 0x00000013/0x00100093/0x00200113 → inst_valid_o every 3rd cycle with inst_pc_o 0x80000000, 0x80000004, 0x80000008 and matching data.
- Backpressure: inst_ready_i low 5 cycles in OUT → inst_o and inst_pc_o unchanged, imem_req_valid_o=0 throughout. Release → next request addr = inst_pc_o+4.
- Redirect in WAIT to 0x80001000, rsp 2 cycles later → that response is never presented. Next request addr is 0x80001000. Also repeat with redirect coincident with rsp, and coincident with req_ready in REQ.
- Misaligned redirect 0x80000002 in OUT → misalign_o pulses 1 cycle, inst_valid_o low for that cycle only, pc and state unchanged.
- Wrap and mid-reset: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second request addr 0. Then rst during WAIT → next request addr back to RESET_PC, and a late rsp arriving in REQ is ignored.
